// File: rtl/div_pkg.sv
// Shared types for the sequential non-restoring divider.
//   state_t     : FSM states of the start/load/iterate/output/done handshake
//   ctrl_t      : per-state control word consumed by the datapath
//   OUT_SEL_*   : encodings of the out_sel output
// Optional feature macro used by the divider: DIVIDER_SIGNED_EN.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE, LOAD_M, LOAD_Q, ITER, CORRECT, OUTPUT_R, OUTPUT_Q, STOP
  } state_t;

  typedef struct packed {
    logic load_m;
    logic load_q;
    logic iter;
    logic correct;
    logic out_rem;
    logic out_quo;
    logic fin;
  } ctrl_t;

  localparam logic OUT_SEL_REM = 1'b0;
  localparam logic OUT_SEL_QUO = 1'b1;

  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c         = '0;
    c.load_m  = (s == LOAD_M);
    c.load_q  = (s == LOAD_Q);
    c.iter    = (s == ITER);
    c.correct = (s == CORRECT);
    c.out_rem = (s == OUTPUT_R);
    c.out_quo = (s == OUTPUT_Q);
    c.fin     = (s == STOP);
    return c;
  endfunction

endpackage

// File: rtl/nonrestoring_divider_addsub.sv
// Shared adder/subtractor for the divider datapath.
//   a, b : operands (WIDTH bits)
//   sub  : 1 -> y = a - b, 0 -> y = a + b
//   y    : result, modulo 2^WIDTH
module addsub #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] y
);

  assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential non-restoring integer divider, one iteration per clock.
// Divisor then dividend arrive on data_in; remainder then quotient leave on
// data_out on two consecutive cycles, followed by a one-cycle done pulse.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : begin a division (sampled in IDLE only)
//   data_in      : divisor (LOAD_M cycle), dividend (LOAD_Q cycle)
//   data_out     : remainder / quotient while out_valid, else 0
//   out_valid    : result present on data_out
//   out_sel      : OUT_SEL_REM / OUT_SEL_QUO, 0 when out_valid is low
//   busy         : not in IDLE
//   done         : one-cycle completion pulse
//   div_by_zero  : last loaded divisor was 0
// Macro DIVIDER_SIGNED_EN: two's-complement operands, truncating division.
module nonrestoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             out_sel,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t                  state_q, state_d;
  ctrl_t                   ctrl;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    dbz_q, dbz_d;
  logic [WIDTH:0]          m_q, m_d;
  logic signed [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0]        q_q, q_d;
  logic [WIDTH-1:0]        dvd_q, dvd_d;
  logic [WIDTH-1:0]        data_out_q, data_out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_sel_q, out_sel_d;
  logic                    done_q, done_d;
  logic [WIDTH:0]          as_a, as_b, as_y;
  logic                    as_sub;
  logic [WIDTH-1:0]        din_mag;
  logic                    neg_q, neg_r;

`ifdef DIVIDER_SIGNED_EN
  logic sgn_m_q, sgn_m_d, sgn_d_q, sgn_d_d;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  endfunction

  assign din_mag = magnitude(data_in);
  // The divide-by-zero result is returned as-is, never sign-fixed.
  assign neg_q   = (sgn_m_q ^ sgn_d_q) & ~dbz_q;
  assign neg_r   = sgn_d_q & ~dbz_q;
`else
  assign din_mag = data_in;
  assign neg_q   = 1'b0;
  assign neg_r   = 1'b0;
`endif

  addsub #(.WIDTH(WIDTH + 1)) u_addsub (
    .a   (as_a),
    .b   (as_b),
    .sub (as_sub),
    .y   (as_y)
  );

  // Adder operand steering. The output states compute 0 +/- value, which is
  // where the signed build applies its sign fix-up; the unsigned build just
  // passes the value through.
  always_comb begin
    ctrl   = decode_ctrl(state_q);
    as_a   = '0;
    as_b   = '0;
    as_sub = 1'b0;
    if (ctrl.iter) begin
      as_a   = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
      as_b   = m_q;
      as_sub = ~a_q[WIDTH];
    end else if (ctrl.correct) begin
      as_a = a_q;
      as_b = m_q;
    end else if (ctrl.out_rem) begin
      as_b   = a_q;
      as_sub = neg_r;
    end else if (ctrl.out_quo) begin
      as_b   = {1'b0, q_q};
      as_sub = neg_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = LOAD_M;
      LOAD_M:   state_d = LOAD_Q;
      LOAD_Q:   state_d = ITER;
      ITER:     if (cnt_q == LAST_ITER) state_d = CORRECT;
      CORRECT:  state_d = OUTPUT_R;
      OUTPUT_R: state_d = OUTPUT_Q;
      OUTPUT_Q: state_d = STOP;
      STOP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    dbz_d = dbz_q;
    m_d   = m_q;
    a_d   = a_q;
    q_d   = q_q;
    dvd_d = dvd_q;
`ifdef DIVIDER_SIGNED_EN
    sgn_m_d = sgn_m_q;
    sgn_d_d = sgn_d_q;
`endif
    if (ctrl.load_m) begin
      m_d   = {1'b0, din_mag};
      dbz_d = (data_in == '0);
`ifdef DIVIDER_SIGNED_EN
      sgn_m_d = data_in[WIDTH-1];
`endif
    end
    if (ctrl.load_q) begin
      q_d   = din_mag;
      dvd_d = data_in;
      a_d   = '0;
      cnt_d = '0;
`ifdef DIVIDER_SIGNED_EN
      sgn_d_d = data_in[WIDTH-1];
`endif
    end
    if (ctrl.iter) begin
      a_d   = as_y;
      q_d   = {q_q[WIDTH-2:0], ~as_y[WIDTH]};
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (ctrl.correct) begin
      if (a_q[WIDTH]) a_d = as_y;
      if (dbz_q) begin
        q_d = '1;
        a_d = {1'b0, dvd_q};
      end
    end
  end

  // Outputs are registered from the current state, so they trail it by one cycle.
  always_comb begin
    out_valid_d = ctrl.out_rem | ctrl.out_quo;
    data_out_d  = out_valid_d ? as_y[WIDTH-1:0] : '0;
    out_sel_d   = ctrl.out_quo ? OUT_SEL_QUO : OUT_SEL_REM;
    done_d      = ctrl.fin;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dbz_q       <= 1'b0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= OUT_SEL_REM;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dbz_q       <= dbz_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      done_q      <= done_d;
    end
  end

  // Datapath registers are always reloaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    m_q   <= m_d;
    a_q   <= a_d;
    q_q   <= q_d;
    dvd_q <= dvd_d;
`ifdef DIVIDER_SIGNED_EN
    sgn_m_q <= sgn_m_d;
    sgn_d_q <= sgn_d_d;
`endif
  end

  assign data_out    = data_out_q;
  assign out_valid   = out_valid_q;
  assign out_sel     = out_sel_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q != IDLE);

endmodule
